// File: rtl/uart_result_tx.sv
// UART 8N1 transmitter that snapshots CPU status (PC, opcode, ALU result, flags)
// and sends it as a 9-byte packet: header, 7 payload bytes, XOR checksum.
module uart_result_tx #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_send,
  input  logic [15:0] i_alu_result_high,
  input  logic [15:0] i_alu_result_low,
  input  logic [4:0]  i_flags,
  input  logic [7:0]  i_current_PC,
  input  logic [7:0]  i_current_Opcode,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [3:0]      byte_idx_q;

  logic [7:0]  pc_q;
  logic [7:0]  opcode_q;
  logic [15:0] res_hi_q;
  logic [15:0] res_lo_q;
  logic [4:0]  flags_q;

  logic [7:0] checksum;
  logic [7:0] cur_byte;
  logic       bit_last;

  assign checksum = pc_q ^ opcode_q ^ res_hi_q[15:8] ^ res_hi_q[7:0] ^
                    res_lo_q[15:8] ^ res_lo_q[7:0] ^ {3'b000, flags_q};
  assign bit_last = (bit_cnt_q == LastCnt);

  always_comb begin
    cur_byte = checksum;
    case (byte_idx_q)
      4'd0:    cur_byte = HEADER_BYTE;
      4'd1:    cur_byte = pc_q;
      4'd2:    cur_byte = opcode_q;
      4'd3:    cur_byte = res_hi_q[15:8];
      4'd4:    cur_byte = res_hi_q[7:0];
      4'd5:    cur_byte = res_lo_q[15:8];
      4'd6:    cur_byte = res_lo_q[7:0];
      4'd7:    cur_byte = {3'b000, flags_q};
      default: cur_byte = checksum;
    endcase
  end

  // o_tx is loaded on the edge that begins each bit, so it always reflects the current bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      pc_q       <= '0;
      opcode_q   <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      flags_q    <= '0;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
          if (i_send) begin
            pc_q       <= i_current_PC;
            opcode_q   <= i_current_Opcode;
            res_hi_q   <= i_alu_result_high;
            res_lo_q   <= i_alu_result_low;
            flags_q    <= i_flags;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            bit_cnt_q  <= '0;
            state_q    <= StStart;
            o_tx       <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        StStart: begin
          if (bit_last) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
            o_tx      <= cur_byte[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_last) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              o_tx    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              o_tx      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_last) begin
            bit_cnt_q <= '0;
            if (byte_idx_q == 4'd8) begin
              state_q <= StIdle;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              o_tx    <= 1'b1;
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
              state_q    <= StStart;
              o_tx       <= 1'b0;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Self-checking bench for uart_result_tx: decodes the serial line against a
// packet model built directly from the byte-order and framing rules.
module tb_uart_result_tx;

  localparam int Cpb    = 4;
  localparam int BitCyc = Cpb;
  localparam int ByteCyc = 10 * Cpb;
  localparam int PktCyc = 90 * Cpb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        send = 1'b0;
  logic [15:0] hi = '0;
  logic [15:0] lo = '0;
  logic [4:0]  fl = '0;
  logic [7:0]  pc = '0;
  logic [7:0]  op = '0;
  logic        tx, busy, done;

  int checks = 0;
  int failures = 0;

  logic txw   [0:799];
  logic busyw [0:799];
  logic donew [0:799];

  always #5 clk = ~clk;

  uart_result_tx #(
    .CLKS_PER_BIT(Cpb),
    .HEADER_BYTE (8'hA5)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_send           (send),
    .i_alu_result_high(hi),
    .i_alu_result_low (lo),
    .i_flags          (fl),
    .i_current_PC     (pc),
    .i_current_Opcode (op),
    .o_tx             (tx),
    .o_busy           (busy),
    .o_done           (done)
  );

  // Packet model: byte b lives at bits [8b+7:8b].
  function automatic logic [71:0] exp_packet(input logic [7:0] p, input logic [7:0] o,
                                             input logic [15:0] h, input logic [15:0] l,
                                             input logic [4:0] f);
    logic [7:0]  b [9];
    logic [71:0] r;
    b[0] = 8'hA5;
    b[1] = p;
    b[2] = o;
    b[3] = h[15:8];
    b[4] = h[7:0];
    b[5] = l[15:8];
    b[6] = l[7:0];
    b[7] = {3'b000, f};
    b[8] = 8'h00;
    for (int i = 1; i <= 7; i++) b[8] = b[8] ^ b[i];
    for (int i = 0; i < 9; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  // Expected line level j cycles after acceptance: start 0, 8 data LSB first, stop 1.
  function automatic logic exp_tx(input logic [71:0] pkt, input int j);
    int         b;
    int         pos;
    logic [7:0] by;
    b   = j / ByteCyc;
    pos = (j % ByteCyc) / BitCyc;
    by  = pkt[8*b +: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return by[pos-1];
  endfunction

  function automatic logic [71:0] decode_packet(input int base);
    logic [71:0] r;
    for (int b = 0; b < 9; b++)
      for (int i = 0; i < 8; i++)
        r[8*b + i] = txw[base + b*ByteCyc + (i+1)*BitCyc + BitCyc/2];
    return r;
  endfunction

  function automatic int wave_errs(input logic [71:0] pkt, input int base);
    int n = 0;
    for (int j = 0; j < PktCyc; j++)
      if (txw[base + j] !== exp_tx(pkt, j)) n++;
    return n;
  endfunction

  task automatic set_inputs(input logic [7:0] p, input logic [7:0] o, input logic [15:0] h,
                            input logic [15:0] l, input logic [4:0] f);
    pc = p; op = o; hi = h; lo = l; fl = f;
  endtask

  task automatic set_random_inputs();
    set_inputs(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 5'($urandom));
  endtask

  // Caller raises send just after a negedge; sample j is taken at the negedge j cycles after acceptance.
  task automatic capture(input int n, input bit hold, input int snap_j, input int p1, input int p2);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == 0 && !hold) send = 1'b0;
      txw[j]   = tx;
      busyw[j] = busy;
      donew[j] = done;
      if (j == snap_j) set_inputs(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 5'h1F);
      if (!hold && (j == p1 - 1 || j == p2 - 1)) send = 1'b1;
      if (!hold && j > 0 && (j == p1 || j == p2)) send = 1'b0;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL idle_hold bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_basic();
    logic [71:0] exp;
    logic [71:0] got;
    int          nbusy = 0, ndone = 0, nstart = 0, werr;
    @(negedge clk);
    set_inputs(8'h12, 8'h05, 16'h0000, 16'h002A, 5'b10001);
    exp  = exp_packet(8'h12, 8'h05, 16'h0000, 16'h002A, 5'b10001);
    send = 1'b1;
    capture(362, 1'b0, -1, -1, -1);
    got = decode_packet(0);
    for (int b = 0; b < 9; b++) begin
      checks++;
      if (got[8*b +: 8] !== exp[8*b +: 8]) begin
        failures++;
        $display("FAIL basic_byte%0d got=%h exp=%h", b, got[8*b +: 8], exp[8*b +: 8]);
      end
    end
    werr = wave_errs(exp, 0);
    checks++; if (werr != 0) begin failures++; $display("FAIL basic_wave bad_cycles=%0d exp=0", werr); end
    for (int j = 0; j < 4; j++) if (txw[j] === 1'b0) nstart++;
    checks++; if (nstart != 4 || txw[4] !== exp[0]) begin
      failures++; $display("FAIL basic_start low_cycles=%0d exp=4", nstart);
    end
    for (int j = 0; j < 362; j++) begin
      if (busyw[j] === 1'b1) nbusy++;
      if (donew[j] === 1'b1) ndone++;
    end
    checks++; if (nbusy != 360 || busyw[359] !== 1'b1) begin
      failures++; $display("FAIL basic_busy cycles=%0d exp=360", nbusy);
    end
    checks++; if (ndone != 1 || donew[360] !== 1'b1) begin
      failures++; $display("FAIL basic_done pulses=%0d at360=%b exp=1,1", ndone, donew[360]);
    end
    checks++; if (txw[360] !== 1'b1 || txw[361] !== 1'b1) begin
      failures++; $display("FAIL basic_tx_idle got=%b%b exp=11", txw[360], txw[361]);
    end
  endtask

  task automatic test_snapshot();
    logic [71:0] exp;
    logic [71:0] got;
    @(negedge clk);
    set_inputs(8'h12, 8'h05, 16'h0000, 16'h002A, 5'b10001);
    exp  = exp_packet(8'h12, 8'h05, 16'h0000, 16'h002A, 5'b10001);
    send = 1'b1;
    capture(362, 1'b0, 0, -1, -1);
    got = decode_packet(0);
    checks++; if (got !== exp) begin failures++; $display("FAIL snapshot_pkt got=%h exp=%h", got, exp); end
    checks++; if (donew[360] !== 1'b1) begin failures++; $display("FAIL snapshot_done got=%b exp=1", donew[360]); end
  endtask

  task automatic test_ignore_busy();
    logic [71:0] exp;
    logic [71:0] got;
    int          ndone = 0, bad_idle = 0;
    @(negedge clk);
    set_random_inputs();
    exp  = exp_packet(pc, op, hi, lo, fl);
    send = 1'b1;
    capture(420, 1'b0, -1, 50, 200);
    got = decode_packet(0);
    for (int j = 0; j < 420; j++) if (donew[j] === 1'b1) ndone++;
    for (int j = 360; j < 420; j++) if (txw[j] !== 1'b1 || busyw[j] !== 1'b0) bad_idle++;
    checks++; if (got !== exp) begin failures++; $display("FAIL ignore_pkt got=%h exp=%h", got, exp); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL ignore_done pulses=%0d exp=1", ndone); end
    checks++; if (bad_idle != 0) begin failures++; $display("FAIL ignore_idle bad_cycles=%0d exp=0", bad_idle); end
  endtask

  task automatic test_random_packets();
    logic [71:0] exp;
    int          werr;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      set_random_inputs();
      exp  = exp_packet(pc, op, hi, lo, fl);
      send = 1'b1;
      capture(362, 1'b0, -1, -1, -1);
      werr = wave_errs(exp, 0);
      checks++; if (werr != 0 || donew[360] !== 1'b1) begin
        failures++; $display("FAIL random%0d_wave bad_cycles=%0d done=%b exp=0,1", n, werr, donew[360]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] exp;
    logic [71:0] got;
    @(negedge clk);
    set_inputs(8'h12, 8'h05, 16'h0000, 16'h002A, 5'b10001);
    exp  = exp_packet(8'h12, 8'h05, 16'h0000, 16'h002A, 5'b10001);
    send = 1'b1;
    capture(126, 1'b0, -1, -1, -1);
    checks++; if (txw[125] !== exp_tx(exp, 125) || busyw[125] !== 1'b1) begin
      failures++; $display("FAIL midreset_pre tx=%b busy=%b exp=%b,1", txw[125], busyw[125], exp_tx(exp, 125));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_async tx=%b busy=%b exp=1,0", tx, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_inputs(8'h01, 8'h00, 16'h0000, 16'h0000, 5'h00);
    exp  = exp_packet(8'h01, 8'h00, 16'h0000, 16'h0000, 5'h00);
    send = 1'b1;
    capture(362, 1'b0, -1, -1, -1);
    got = decode_packet(0);
    checks++; if (got !== exp) begin failures++; $display("FAIL midreset_pkt got=%h exp=%h", got, exp); end
    checks++; if (donew[360] !== 1'b1) begin failures++; $display("FAIL midreset_done got=%b exp=1", donew[360]); end
  endtask

  task automatic test_back_to_back();
    logic [71:0] exp;
    int          nlow = 0, ndone = 0, werr0, werr1, wait_cnt = 0;
    bit          seen = 0;
    @(negedge clk);
    set_random_inputs();
    exp  = exp_packet(pc, op, hi, lo, fl);
    send = 1'b1;
    capture(800, 1'b1, -1, -1, -1);
    send = 1'b0;
    for (int j = 0; j < 722; j++) begin
      if (busyw[j] !== 1'b1) nlow++;
      if (donew[j] === 1'b1) ndone++;
    end
    checks++; if (nlow != 2 || busyw[360] !== 1'b0 || busyw[721] !== 1'b0) begin
      failures++; $display("FAIL b2b_busy low_cycles=%0d exp=2 at 360,721", nlow);
    end
    checks++; if (ndone != 2 || donew[360] !== 1'b1 || donew[721] !== 1'b1) begin
      failures++; $display("FAIL b2b_done pulses=%0d exp=2", ndone);
    end
    werr0 = wave_errs(exp, 0);
    werr1 = wave_errs(exp, 361);
    checks++; if (werr0 != 0) begin failures++; $display("FAIL b2b_pkt0 bad_cycles=%0d exp=0", werr0); end
    checks++; if (werr1 != 0) begin failures++; $display("FAIL b2b_pkt1 bad_cycles=%0d exp=0", werr1); end
    checks++; if (txw[722] !== 1'b0 || busyw[722] !== 1'b1) begin
      failures++; $display("FAIL b2b_third_start tx=%b busy=%b exp=0,1", txw[722], busyw[722]);
    end
    // Third packet was accepted while the request was held; let it drain.
    while (!seen && wait_cnt < 500) begin
      @(negedge clk);
      wait_cnt++;
      if (done === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL b2b_drain done_seen=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_ignore_busy();
    test_random_packets();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
